// File: rtl/fp16_acc_feeder_pkg.sv
// fp16 accumulator feeder: shared types and constants.
// Provides fp16 field widths, idle/max-finite codes, FSM state enum, FTZ helper.
package fp16_pkg;

   localparam int FP16_W = 16;
   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;

   localparam logic [FP16_W-1:0] FP16_IDLE       = 16'h0000;
   localparam logic [FP16_W-1:0] FP16_MAXFIN_POS = 16'h7BFF;
   localparam logic [FP16_W-1:0] FP16_MAXFIN_NEG = 16'hFBFF;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } feed_state_t;

   // Zero/subnormal -> +0, Inf/NaN -> sign-preserving max-finite.
   function automatic logic [FP16_W-1:0] fp16_ftz(
      input logic [FP16_W-1:0] v
   );
      logic [EXP_W-1:0] e;
      e = v[FP16_W-2 -: EXP_W];
      if (e == '0)
         return FP16_IDLE;
      if (e == '1)
         return v[FP16_W-1] ? FP16_MAXFIN_NEG : FP16_MAXFIN_POS;
      return v;
   endfunction

endpackage

// File: rtl/fp16_acc_feeder_if.sv
// fp16 accumulator feeder bus: upstream stream, flush, accumulator side, status.
// master = producer/observer (testbench), slave = fp16_acc_feeder.
interface fp16_acc_feeder_if;
   import fp16_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [FP16_W-1:0] s_data;
   logic              flush_req;
   logic [FP16_W-1:0] out_a;
   logic              out_accum_done;
   logic [15:0]       out_group_cnt;
   logic              busy;

   modport master (
      output s_valid,
      output s_data,
      output flush_req,
      input  s_ready,
      input  out_a,
      input  out_accum_done,
      input  out_group_cnt,
      input  busy
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  flush_req,
      output s_ready,
      output out_a,
      output out_accum_done,
      output out_group_cnt,
      output busy
   );

endinterface

// File: rtl/fp16_sync_fifo.sv
// Single-clock FIFO with registered count; full/empty derive from the count.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data (head, not show-through), full, empty.
module fp16_sync_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_rd)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)
            count <= count + (AW+1)'(1);
         else if (do_rd && !do_wr)
            count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fp16_acc_feeder.sv
// Feeds buffered fp16 operands one per cycle to the accumulator, strobing
// done on each group's last element and zero-padding groups closed by flush.
// Ports: clk, rst (async, active-high), bus (fp16_acc_feeder_if.slave):
//   s_valid/s_ready/s_data in, flush_req in, out_a/out_accum_done/
//   out_group_cnt/busy out.
// Macro FP16_FEED_FTZ_EN: flush denormals to zero and clamp Inf/NaN on push.
module fp16_acc_feeder
   import fp16_pkg::*;
#(
   parameter int VEC_LEN    = 16,
   parameter int FIFO_DEPTH = 32
) (
   input logic             clk,
   input logic             rst,
   fp16_acc_feeder_if.slave bus
);

   localparam int CW = $clog2(VEC_LEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

   feed_state_t       state_q;
   feed_state_t       state_d;
   logic [CW-1:0]     elem_q;
   logic [CW-1:0]     elem_d;
   logic [FP16_W-1:0] a_q;
   logic              done_q;
   logic [15:0]       grp_q;
   logic              rdy_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [FP16_W-1:0] fifo_wdata;
   logic [FP16_W-1:0] fifo_rdata;
   logic              push;
   logic              pop;
   logic              pad;
   logic              issue;
   logic              last;

   // rdy_q keeps s_ready low while reset is held.
   assign bus.s_ready        = rdy_q & ~fifo_full;
   assign bus.out_a          = a_q;
   assign bus.out_accum_done = done_q;
   assign bus.out_group_cnt  = grp_q;
   assign bus.busy           = (state_q != IDLE) | ~fifo_empty;

   assign push = bus.s_valid & bus.s_ready;

`ifdef FP16_FEED_FTZ_EN
   assign fifo_wdata = fp16_ftz(bus.s_data);
`else
   assign fifo_wdata = bus.s_data;
`endif

   fp16_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FP16_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      pad     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            pop = !fifo_empty;
            if (bus.flush_req && elem_q != '0)
               state_d = FLUSH;
         end
         FLUSH: begin
            pop = !fifo_empty;
            pad = fifo_empty;
         end
         default: state_d = IDLE;
      endcase
      issue = pop | pad;
      last  = issue && (elem_q == LAST);
      // Completion wins over a coincident flush; IDLE restarts at once
      // if more data is already buffered, so no bubble is lost.
      if (last)
         state_d = IDLE;
      elem_d = elem_q;
      if (issue)
         elem_d = last ? '0 : elem_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         elem_q  <= '0;
         a_q     <= FP16_IDLE;
         done_q  <= 1'b0;
         grp_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         a_q     <= pop ? fifo_rdata : FP16_IDLE;
         done_q  <= last;
         grp_q   <= grp_q + 16'(last);
         rdy_q   <= 1'b1;
      end
   end

endmodule
